decode_stage_control: RTL and testbench

Decode-stage controller for the RV32IM pipeline. It classifies the instruction in IF/ID, drives the select and field inputs of the immediate generator, and captures the generated immediate and register fields into the ID/EX register. It runs a valid/ready handshake toward both fetch and execute, inserts a one-cycle bubble on load-use hazards, and honours branch flushes.

---
 rtl/decode_stage_control_if.sv | 48 ++++
 rtl/decode_stage_control.sv | 206 ++++++++++++++++++++
 tb/tb_decode_stage_control.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_control_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_control_if
// Description : Fetch, immediate-generator and execute side signals of the
//               RV32IM decode-stage controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_control_if #(
  parameter int STALL_W = 16
);
  // fetch side
  logic               IF_VALID;
  logic               IF_READY;
  logic [31:0]        IF_INSTR;
  logic [31:0]        IF_PC;
  logic               FLUSH;
  // immediate generator
  logic [2:0]         IMM_SEL;
  logic [24:0]        IMM_IN;
  logic [31:0]        IMM_VALUE;
  // execute side
  logic               EX_VALID;
  logic               EX_READY;
  logic [31:0]        EX_IMM;
  logic [31:0]        EX_PC;
  logic [4:0]         EX_RD;
  logic [4:0]         EX_RS1;
  logic [4:0]         EX_RS2;
  logic               EX_ILLEGAL;
  logic [STALL_W-1:0] STALL_COUNT;

  // Decode stage view
  modport slave (
    input  IF_VALID, IF_INSTR, IF_PC, FLUSH, IMM_VALUE, EX_READY,
    output IF_READY, IMM_SEL, IMM_IN,
    output EX_VALID, EX_IMM, EX_PC, EX_RD, EX_RS1, EX_RS2, EX_ILLEGAL,
    output STALL_COUNT
  );

  // Environment view: fetch, immediate generator and execute
  modport master (
    output IF_VALID, IF_INSTR, IF_PC, FLUSH, IMM_VALUE, EX_READY,
    input  IF_READY, IMM_SEL, IMM_IN,
    input  EX_VALID, EX_IMM, EX_PC, EX_RD, EX_RS1, EX_RS2, EX_ILLEGAL,
    input  STALL_COUNT
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_control.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_control
// Description : RV32IM decode-stage controller: immediate select decode,
//               ID/EX register, load-use bubble insertion and flush handling.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_control #(
  parameter int STALL_W = 16
) (
  input  wire logic             CLK,
  input  wire logic             RESET,
  decode_stage_control_if.slave bus
);

  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;

  localparam logic [2:0] c_SEL_U     = 3'b000;
  localparam logic [2:0] c_SEL_J     = 3'b001;
  localparam logic [2:0] c_SEL_S     = 3'b010;
  localparam logic [2:0] c_SEL_B     = 3'b011;
  localparam logic [2:0] c_SEL_I     = 3'b100;
  localparam logic [2:0] c_SEL_SHAMT = 3'b101;
  localparam logic [2:0] c_SEL_ZERO  = 3'b111;

  localparam logic [STALL_W-1:0] c_STALL_MAX = {STALL_W{1'b1}};

  // instruction fields
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [4:0] w_rd;
  logic [4:0] w_rs1;
  logic [4:0] w_rs2;

  assign w_opcode = bus.IF_INSTR[6:0];
  assign w_funct3 = bus.IF_INSTR[14:12];
  assign w_rd     = bus.IF_INSTR[11:7];
  assign w_rs1    = bus.IF_INSTR[19:15];
  assign w_rs2    = bus.IF_INSTR[24:20];

  // classification
  logic [2:0] w_imm_sel;
  logic       w_illegal;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  logic       w_is_load;

  always_comb begin
    w_imm_sel  = c_SEL_ZERO;
    w_illegal  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_is_load  = 1'b0;
    case (w_opcode)
      c_OPC_LUI, c_OPC_AUIPC: w_imm_sel = c_SEL_U;
      c_OPC_JAL:              w_imm_sel = c_SEL_J;
      c_OPC_STORE: begin
        w_imm_sel  = c_SEL_S;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_OPC_BRANCH: begin
        w_imm_sel  = c_SEL_B;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      c_OPC_LOAD: begin
        w_imm_sel  = c_SEL_I;
        w_uses_rs1 = 1'b1;
        w_is_load  = 1'b1;
      end
      c_OPC_JALR: begin
        w_imm_sel  = c_SEL_I;
        w_uses_rs1 = 1'b1;
      end
      c_OPC_OPIMM: begin
        // SLLI/SRLI/SRAI carry a shift amount, not a signed immediate
        w_imm_sel  = (w_funct3 == 3'b001 || w_funct3 == 3'b101) ? c_SEL_SHAMT : c_SEL_I;
        w_uses_rs1 = 1'b1;
      end
      c_OPC_OP: begin
        w_imm_sel  = c_SEL_ZERO;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      default: begin
        w_imm_sel = c_SEL_ZERO;
        w_illegal = 1'b1;
      end
    endcase
  end

  // state
  logic               ex_valid_q,     ex_valid_d;
  logic [31:0]        ex_imm_q,       ex_imm_d;
  logic [31:0]        ex_pc_q,        ex_pc_d;
  logic [4:0]         ex_rd_q,        ex_rd_d;
  logic [4:0]         ex_rs1_q,       ex_rs1_d;
  logic [4:0]         ex_rs2_q,       ex_rs2_d;
  logic               ex_illegal_q,   ex_illegal_d;
  logic               load_pending_q, load_pending_d;
  logic [4:0]         load_rd_q,      load_rd_d;
  logic [STALL_W-1:0] stall_count_q,  stall_count_d;

  // handshake
  logic w_slot_free;
  logic w_hazard;
  logic w_if_ready;
  logic w_accept;

  assign w_slot_free = !ex_valid_q || bus.EX_READY;
  assign w_hazard    = load_pending_q && bus.IF_VALID &&
                       ((w_uses_rs1 && (w_rs1 == load_rd_q)) ||
                        (w_uses_rs2 && (w_rs2 == load_rd_q)));
  assign w_if_ready  = RESET && !bus.FLUSH && !w_hazard && w_slot_free;
  assign w_accept    = bus.IF_VALID && w_if_ready;

  always_comb begin
    ex_valid_d     = ex_valid_q;
    ex_imm_d       = ex_imm_q;
    ex_pc_d        = ex_pc_q;
    ex_rd_d        = ex_rd_q;
    ex_rs1_d       = ex_rs1_q;
    ex_rs2_d       = ex_rs2_q;
    ex_illegal_d   = ex_illegal_q;
    load_pending_d = load_pending_q;
    load_rd_d      = load_rd_q;
    stall_count_d  = stall_count_q;

    if (bus.FLUSH) begin
      ex_valid_d     = 1'b0;
      load_pending_d = 1'b0;
    end else if (w_accept) begin
      ex_valid_d   = 1'b1;
      ex_imm_d     = bus.IMM_VALUE;
      ex_pc_d      = bus.IF_PC;
      ex_rd_d      = w_rd;
      ex_rs1_d     = w_rs1;
      ex_rs2_d     = w_rs2;
      ex_illegal_d = w_illegal;
      // a load into x0 never produces a value to wait for
      if (w_is_load && (w_rd != 5'd0)) begin
        load_pending_d = 1'b1;
        load_rd_d      = w_rd;
      end else begin
        load_pending_d = 1'b0;
      end
    end else if (w_hazard && w_slot_free) begin
      ex_valid_d     = 1'b0;
      load_pending_d = 1'b0;
      if (stall_count_q != c_STALL_MAX) begin
        stall_count_d = stall_count_q + STALL_W'(1);
      end
    end else if (bus.EX_READY) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      ex_valid_q     <= 1'b0;
      ex_imm_q       <= 32'd0;
      ex_pc_q        <= 32'd0;
      ex_rd_q        <= 5'd0;
      ex_rs1_q       <= 5'd0;
      ex_rs2_q       <= 5'd0;
      ex_illegal_q   <= 1'b0;
      load_pending_q <= 1'b0;
      load_rd_q      <= 5'd0;
      stall_count_q  <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_imm_q       <= ex_imm_d;
      ex_pc_q        <= ex_pc_d;
      ex_rd_q        <= ex_rd_d;
      ex_rs1_q       <= ex_rs1_d;
      ex_rs2_q       <= ex_rs2_d;
      ex_illegal_q   <= ex_illegal_d;
      load_pending_q <= load_pending_d;
      load_rd_q      <= load_rd_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bus.IF_READY    = w_if_ready;
  assign bus.IMM_SEL     = w_imm_sel;
  assign bus.IMM_IN      = bus.IF_INSTR[31:7];
  assign bus.EX_VALID    = ex_valid_q;
  assign bus.EX_IMM      = ex_imm_q;
  assign bus.EX_PC       = ex_pc_q;
  assign bus.EX_RD       = ex_rd_q;
  assign bus.EX_RS1      = ex_rs1_q;
  assign bus.EX_RS2      = ex_rs2_q;
  assign bus.EX_ILLEGAL  = ex_illegal_q;
  assign bus.STALL_COUNT = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage_control
// Description : Directed-vector bench for decode_stage_control with a small
//               immediate-generator model on the IMM_SEL/IMM_IN path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_control;

  localparam int STALL_W = 16;

  logic CLK;
  logic RESET;
  int   n_vec;
  int   n_err;

  decode_stage_control_if #(.STALL_W(STALL_W)) bus ();

  decode_stage_control #(.STALL_W(STALL_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // immediate generator: IMM_IN holds INSTR[31:7], so INSTR[k] = in[k-7]
  function automatic logic [31:0] immgen(input logic [2:0] sel, input logic [24:0] in);
    logic [31:0] ins;
    ins = {in, 7'd0};
    case (sel)
      3'b000:  immgen = {ins[31:12], 12'd0};
      3'b001:  immgen = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b010:  immgen = {{21{ins[31]}}, ins[30:25], ins[11:7]};
      3'b011:  immgen = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b100:  immgen = {{21{ins[31]}}, ins[30:20]};
      3'b101:  immgen = {27'd0, ins[24:20]};
      default: immgen = 32'd0;
    endcase
  endfunction

  always_comb bus.IMM_VALUE = immgen(bus.IMM_SEL, bus.IMM_IN);

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // one clock, leaving the bench 1 time unit past the rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    bus.IF_VALID = v;
    bus.IF_INSTR = instr;
    bus.IF_PC    = pc;
  endtask

  localparam logic [31:0] c_ADDI_X1 = 32'hFFF00093;
  localparam logic [31:0] c_LW_X5   = 32'h00012283;
  localparam logic [31:0] c_ADD_X6  = 32'h00528333;
  localparam logic [31:0] c_LUI_X5  = 32'h000012B7;
  localparam logic [31:0] c_LW_X0   = 32'h00012003;
  localparam logic [31:0] c_ADD_X0  = 32'h00000333;

  // instruction, expected IMM_SEL, expected EX_IMM, expected EX_ILLEGAL
  logic [31:0] tbl_instr [7];
  logic [2:0]  tbl_sel   [7];
  logic [31:0] tbl_imm   [7];
  logic        tbl_ill   [7];

  initial begin
    tbl_instr[0] = c_ADDI_X1;    tbl_sel[0] = 3'b100; tbl_imm[0] = 32'hFFFFFFFF; tbl_ill[0] = 1'b0;
    tbl_instr[1] = c_LUI_X5;     tbl_sel[1] = 3'b000; tbl_imm[1] = 32'h00001000; tbl_ill[1] = 1'b0;
    tbl_instr[2] = 32'h00512423; tbl_sel[2] = 3'b010; tbl_imm[2] = 32'h00000008; tbl_ill[2] = 1'b0;
    tbl_instr[3] = 32'h00309093; tbl_sel[3] = 3'b101; tbl_imm[3] = 32'h00000003; tbl_ill[3] = 1'b0;
    tbl_instr[4] = 32'h00000463; tbl_sel[4] = 3'b011; tbl_imm[4] = 32'h00000008; tbl_ill[4] = 1'b0;
    tbl_instr[5] = 32'h010000EF; tbl_sel[5] = 3'b001; tbl_imm[5] = 32'h00000010; tbl_ill[5] = 1'b0;
    tbl_instr[6] = 32'h0000007F; tbl_sel[6] = 3'b111; tbl_imm[6] = 32'h00000000; tbl_ill[6] = 1'b1;
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    RESET = 1'b0;
    bus.FLUSH    = 1'b0;
    bus.EX_READY = 1'b1;
    drive(1'b0, 32'd0, 32'd0);
    cyc();
    cyc();

    // reset state
    chk("rst_ex_valid", 32'(bus.EX_VALID), 32'd0);
    chk("rst_ex_imm", bus.EX_IMM, 32'd0);
    chk("rst_stall", 32'(bus.STALL_COUNT), 32'd0);
    chk("rst_if_ready", 32'(bus.IF_READY), 32'd0);
    RESET = 1'b1;
    #1;
    chk("post_rst_if_ready", 32'(bus.IF_READY), 32'd1);

    // ADDI x1,x0,-1
    drive(1'b1, c_ADDI_X1, 32'h100);
    #1;
    chk("addi_imm_sel", 32'(bus.IMM_SEL), 32'd4);
    chk("addi_imm_in", 32'(bus.IMM_IN), 32'h01FFE001);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("addi_ex_valid", 32'(bus.EX_VALID), 32'd1);
    chk("addi_ex_imm", bus.EX_IMM, 32'hFFFFFFFF);
    chk("addi_ex_rd", 32'(bus.EX_RD), 32'd1);
    chk("addi_ex_ill", 32'(bus.EX_ILLEGAL), 32'd0);
    chk("addi_ex_pc", bus.EX_PC, 32'h100);
    cyc();
    chk("addi_drain", 32'(bus.EX_VALID), 32'd0);

    // LW x5 then dependent ADD: one bubble
    drive(1'b1, c_LW_X5, 32'h104);
    #1;
    chk("lw_if_ready", 32'(bus.IF_READY), 32'd1);
    cyc();
    drive(1'b1, c_ADD_X6, 32'h108);
    #1;
    chk("hz_if_ready", 32'(bus.IF_READY), 32'd0);
    chk("hz_lw_rd", 32'(bus.EX_RD), 32'd5);
    chk("add_imm_sel", 32'(bus.IMM_SEL), 32'd7);
    cyc();
    chk("bubble_valid", 32'(bus.EX_VALID), 32'd0);
    chk("bubble_if_ready", 32'(bus.IF_READY), 32'd1);
    chk("bubble_stall", 32'(bus.STALL_COUNT), 32'd1);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("add_valid", 32'(bus.EX_VALID), 32'd1);
    chk("add_rd", 32'(bus.EX_RD), 32'd6);
    chk("add_rs1", 32'(bus.EX_RS1), 32'd5);
    chk("add_rs2", 32'(bus.EX_RS2), 32'd5);
    chk("add_imm", bus.EX_IMM, 32'd0);
    chk("add_pc", bus.EX_PC, 32'h108);
    cyc();

    // LW x5 then LUI x5: no stall
    drive(1'b1, c_LW_X5, 32'h10C);
    cyc();
    drive(1'b1, c_LUI_X5, 32'h110);
    #1;
    chk("lui_if_ready", 32'(bus.IF_READY), 32'd1);
    chk("lui_imm_sel", 32'(bus.IMM_SEL), 32'd0);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("lui_imm", bus.EX_IMM, 32'h00001000);
    chk("lui_pc", bus.EX_PC, 32'h110);
    chk("lui_stall", 32'(bus.STALL_COUNT), 32'd1);

    // LW x0 then ADD using x0: no stall
    drive(1'b1, c_LW_X0, 32'h114);
    cyc();
    drive(1'b1, c_ADD_X0, 32'h118);
    #1;
    chk("x0_if_ready", 32'(bus.IF_READY), 32'd1);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("x0_pc", bus.EX_PC, 32'h118);
    chk("x0_stall", 32'(bus.STALL_COUNT), 32'd1);
    cyc();

    // backpressure for 3 cycles
    drive(1'b1, c_ADDI_X1, 32'h200);
    cyc();
    bus.EX_READY = 1'b0;
    drive(1'b1, c_LUI_X5, 32'h204);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_if_ready", 32'(bus.IF_READY), 32'd0);
      chk("bp_valid", 32'(bus.EX_VALID), 32'd1);
      chk("bp_pc", bus.EX_PC, 32'h200);
      chk("bp_imm", bus.EX_IMM, 32'hFFFFFFFF);
      cyc();
    end
    bus.EX_READY = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.IF_READY), 32'd1);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("bp_next_pc", bus.EX_PC, 32'h204);
    chk("bp_next_imm", bus.EX_IMM, 32'h00001000);
    cyc();

    // flush during pending hazard
    drive(1'b1, c_LW_X5, 32'h300);
    cyc();
    drive(1'b1, c_ADD_X6, 32'h304);
    bus.FLUSH = 1'b1;
    #1;
    chk("fl_if_ready", 32'(bus.IF_READY), 32'd0);
    cyc();
    bus.FLUSH = 1'b0;
    chk("fl_valid", 32'(bus.EX_VALID), 32'd0);
    chk("fl_stall", 32'(bus.STALL_COUNT), 32'd1);
    #1;
    chk("fl_add_ready", 32'(bus.IF_READY), 32'd1);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("fl_add_valid", 32'(bus.EX_VALID), 32'd1);
    chk("fl_add_pc", bus.EX_PC, 32'h304);
    chk("fl_add_stall", 32'(bus.STALL_COUNT), 32'd1);

    // immediate-format table, back to back
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl_instr[i], 32'h400 + 32'(i * 4));
      #1;
      chk($sformatf("tbl%0d_sel", i), 32'(bus.IMM_SEL), 32'(tbl_sel[i]));
      cyc();
      chk($sformatf("tbl%0d_imm", i), bus.EX_IMM, tbl_imm[i]);
      chk($sformatf("tbl%0d_ill", i), 32'(bus.EX_ILLEGAL), 32'(tbl_ill[i]));
      chk($sformatf("tbl%0d_valid", i), 32'(bus.EX_VALID), 32'd1);
    end
    drive(1'b0, 32'd0, 32'd0);
    cyc();

    // reset mid-stall under backpressure
    drive(1'b1, c_LW_X5, 32'h500);
    cyc();
    drive(1'b1, c_ADD_X6, 32'h504);
    bus.EX_READY = 1'b0;
    RESET = 1'b0;
    #1;
    chk("mrst_if_ready", 32'(bus.IF_READY), 32'd0);
    cyc();
    chk("mrst_valid", 32'(bus.EX_VALID), 32'd0);
    chk("mrst_pc", bus.EX_PC, 32'd0);
    chk("mrst_rd", 32'(bus.EX_RD), 32'd0);
    chk("mrst_imm", bus.EX_IMM, 32'd0);
    chk("mrst_stall", 32'(bus.STALL_COUNT), 32'd0);
    RESET = 1'b1;
    bus.EX_READY = 1'b1;
    #1;
    chk("mrst_no_pending", 32'(bus.IF_READY), 32'd1);
    cyc();
    drive(1'b0, 32'd0, 32'd0);
    chk("mrst_add_pc", bus.EX_PC, 32'h504);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
